// File: rtl/out_frame_pkg.sv
// Shared definitions for the framed serial transmitter: FSM states, frame
// length, default sync byte and the checksum rule.
package out_frame_pkg;

    localparam int unsigned FRAME_BYTES       = 11;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT,
        DONE_ST
    } tx_state_t;

    // The sync byte is deliberately left out of the checksum.
    function automatic logic [7:0] frame_checksum(
        input logic [7:0]  flags,
        input logic [15:0] w1,
        input logic [15:0] w2,
        input logic [15:0] w3,
        input logic [15:0] w4
    );
        return flags
             ^ w1[15:8] ^ w1[7:0]
             ^ w2[15:8] ^ w2[7:0]
             ^ w3[15:8] ^ w3[7:0]
             ^ w4[15:8] ^ w4[7:0];
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Brings the 1 MHz reference into the CLK domain and emits a one-cycle TICK
// on each synchronised rising edge.
module tick_edge_sync (
    input  logic CLK,
    input  logic RST,
    input  logic CLK_1MHz,
    output logic TICK
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= CLK_1MHz;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign TICK = sync2_q & ~prev_q;

endmodule

// File: rtl/out_frame_tx.sv
// Snapshots flags and four words on START and sends them as an 11-byte 8N1
// frame (sync, flags, words hi/lo, checksum) at one bit per reference tick.
module out_frame_tx
    import out_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
    parameter logic       IDLE_LEVEL = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CLK_1MHz,
    input  logic               START,
    input  logic [7:0]         FLAGS,
    input  logic [15:0]        WORD1,
    input  logic [15:0]        WORD2,
    input  logic [15:0]        WORD3,
    input  logic signed [15:0] WORD4,
    output logic               TX,
    output logic               BUSY,
    output logic               DONE
);

    logic       tick;

    tx_state_t  state_q;
    tx_state_t  state_n;
    logic [3:0] byte_idx_q;
    logic [3:0] byte_idx_n;
    logic [2:0] bit_idx_q;
    logic [2:0] bit_idx_n;
    logic       tx_q;
    logic       tx_n;
    logic       busy_q;
    logic       busy_n;

    logic [7:0]  flags_q;
    logic [15:0] word1_q;
    logic [15:0] word2_q;
    logic [15:0] word3_q;
    logic [15:0] word4_q;
    logic [7:0]  chk;
    logic [7:0]  cur_byte;
    logic        accept;

    tick_edge_sync u_tick (
        .CLK      (CLK),
        .RST      (RST),
        .CLK_1MHz (CLK_1MHz),
        .TICK     (tick)
    );

    // BUSY is low only in IDLE and in the DONE cycle, so this also admits a
    // back-to-back START coinciding with DONE.
    assign accept = START & ~busy_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flags_q <= '0;
            word1_q <= '0;
            word2_q <= '0;
            word3_q <= '0;
            word4_q <= '0;
        end else if (accept) begin
            flags_q <= FLAGS;
            word1_q <= WORD1;
            word2_q <= WORD2;
            word3_q <= WORD3;
            word4_q <= WORD4;
        end
    end

    assign chk = frame_checksum(flags_q, word1_q, word2_q, word3_q, word4_q);

    always_comb begin
        cur_byte = '0;
        case (byte_idx_q)
            4'd0:    cur_byte = SYNC_BYTE;
            4'd1:    cur_byte = flags_q;
            4'd2:    cur_byte = word1_q[15:8];
            4'd3:    cur_byte = word1_q[7:0];
            4'd4:    cur_byte = word2_q[15:8];
            4'd5:    cur_byte = word2_q[7:0];
            4'd6:    cur_byte = word3_q[15:8];
            4'd7:    cur_byte = word3_q[7:0];
            4'd8:    cur_byte = word4_q[15:8];
            4'd9:    cur_byte = word4_q[7:0];
            4'd10:   cur_byte = chk;
            default: cur_byte = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            byte_idx_q <= byte_idx_n;
            bit_idx_q  <= bit_idx_n;
            tx_q       <= tx_n;
            busy_q     <= busy_n;
        end
    end

    // TX is registered alongside the state so it only ever moves on TICK.
    always_comb begin
        state_n    = state_q;
        byte_idx_n = byte_idx_q;
        bit_idx_n  = bit_idx_q;
        tx_n       = tx_q;
        busy_n     = busy_q;

        if (accept) begin
            busy_n = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (busy_q && tick) begin
                    state_n = START_BIT;
                    tx_n    = 1'b0;
                end
            end
            START_BIT: begin
                if (tick) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = cur_byte[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_n = STOP_BIT;
                        tx_n    = IDLE_LEVEL;
                    end else begin
                        bit_idx_n = bit_idx_q + 3'd1;
                        tx_n      = cur_byte[bit_idx_q + 3'd1];
                    end
                end
            end
            STOP_BIT: begin
                if (tick) begin
                    if (byte_idx_q == 4'(FRAME_BYTES - 1)) begin
                        state_n = DONE_ST;
                        busy_n  = 1'b0;
                    end else begin
                        state_n    = START_BIT;
                        byte_idx_n = byte_idx_q + 4'd1;
                        bit_idx_n  = '0;
                        tx_n       = 1'b0;
                    end
                end
            end
            DONE_ST: begin
                state_n    = IDLE;
                byte_idx_n = '0;
                bit_idx_n  = '0;
            end
            default: begin
                state_n    = IDLE;
                byte_idx_n = '0;
                bit_idx_n  = '0;
                tx_n       = IDLE_LEVEL;
                busy_n     = 1'b0;
            end
        endcase
    end

    assign TX   = tx_q;
    assign BUSY = busy_q;
    assign DONE = (state_q == DONE_ST);

endmodule

// File: tb/tb_out_frame_tx.sv
// Directed bench for out_frame_tx: decodes TX at mid-bit of the reference
// clock and compares every byte, DONE/BUSY timing and reset behaviour.
module tb_out_frame_tx;

    logic               CLK;
    logic               RST;
    logic               CLK_1MHz;
    logic               START;
    logic [7:0]         FLAGS;
    logic [15:0]        WORD1;
    logic [15:0]        WORD2;
    logic [15:0]        WORD3;
    logic signed [15:0] WORD4;
    logic               TX;
    logic               BUSY;
    logic               DONE;

    int checks   = 0;
    int failures = 0;
    int ref_rises = 0;
    int done_cnt  = 0;
    int tx_edges  = 0;

    logic [7:0] exp_bytes [11];

    out_frame_tx #(
        .SYNC_BYTE  (8'hA5),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CLK_1MHz (CLK_1MHz),
        .START    (START),
        .FLAGS    (FLAGS),
        .WORD1    (WORD1),
        .WORD2    (WORD2),
        .WORD3    (WORD3),
        .WORD4    (WORD4),
        .TX       (TX),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    // 100 MHz system clock; reference scaled to 16 CLK per bit, phase-offset
    // so its edges never coincide with CLK edges.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        CLK_1MHz = 1'b0;
        #2;
        forever #80 CLK_1MHz = ~CLK_1MHz;
    end

    always @(posedge CLK_1MHz) ref_rises++;
    always @(negedge CLK) if (DONE === 1'b1) done_cnt++;
    always @(TX) tx_edges++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic set_inputs(input logic [7:0] f, input logic [15:0] w1, input logic [15:0] w2,
                              input logic [15:0] w3, input logic [15:0] w4);
        FLAGS = f;
        WORD1 = w1;
        WORD2 = w2;
        WORD3 = w3;
        WORD4 = w4;
    endtask

    task automatic wait_tx_fall(output int r0);
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (TX === 1'b0) break;
        end
        check("start_edge", {31'd0, TX}, 32'd0);
        r0 = ref_rises;
    endtask

    // Each byte is {stop, data LSB-first, start}, sampled on reference falls.
    task automatic recv_frame(output int r0);
        logic [9:0] w;
        wait_tx_fall(r0);
        for (int k = 0; k < 11; k++) begin
            for (int b = 0; b < 10; b++) begin
                @(negedge CLK_1MHz);
                w[b] = TX;
            end
            check($sformatf("byte%0d", k), {22'd0, w}, {22'd0, 1'b1, exp_bytes[k], 1'b0});
        end
    endtask

    task automatic wait_done(input int r0, input bit restart, output int rd);
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) break;
        end
        rd = ref_rises;
        check("done_seen", {31'd0, DONE}, 32'd1);
        check("done_busy", {31'd0, BUSY}, 32'd0);
        check("frame_ticks", rd - r0, 32'd110);
        if (restart) START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("done_width", {31'd0, DONE}, 32'd0);
        if (restart) check("b2b_busy", {31'd0, BUSY}, 32'd1);
    endtask

    initial begin
        int r0;
        int r1;
        int rd;
        int d0;
        int e0;

        RST   = 1'b1;
        START = 1'b0;
        set_inputs(8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // reset state and quiet line afterwards
        repeat (5) @(negedge CLK);
        check("rst_tx",   {31'd0, TX},   32'd1);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        e0 = tx_edges;
        repeat (20) @(posedge CLK_1MHz);
        @(negedge CLK);
        check("idle_edges", tx_edges - e0, 32'd0);
        check("idle_tx", {31'd0, TX}, 32'd1);

        // basic frame content
        set_inputs(8'h00, 16'h1234, 16'h0000, 16'h0000, 16'h0000);
        exp_bytes = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h26};
        d0 = done_cnt;
        pulse_start();
        check("busy_rise", {31'd0, BUSY}, 32'd1);
        recv_frame(r0);
        wait_done(r0, 1'b0, rd);
        check("done_count_a", done_cnt - d0, 32'd1);

        // signed word sent as raw bits
        set_inputs(8'h81, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE);
        exp_bytes = '{8'hA5, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'h80};
        pulse_start();
        recv_frame(r0);
        wait_done(r0, 1'b0, rd);

        // snapshot: inputs and START changed mid-frame must not disturb it
        set_inputs(8'h3C, 16'hABCD, 16'h0102, 16'h8000, 16'h7FFF);
        exp_bytes = '{8'hA5, 8'h3C, 8'hAB, 8'hCD, 8'h01, 8'h02, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h59};
        d0 = done_cnt;
        pulse_start();
        fork
            begin
                recv_frame(r0);
                wait_done(r0, 1'b0, rd);
            end
            begin
                repeat (30) @(posedge CLK_1MHz);
                @(negedge CLK);
                WORD1 = 16'hFFFF;
                FLAGS = 8'hFF;
                pulse_start();
            end
        join
        e0 = tx_edges;
        repeat (4) @(posedge CLK_1MHz);
        @(negedge CLK);
        check("snap_no_second_frame", tx_edges - e0, 32'd0);
        check("snap_busy", {31'd0, BUSY}, 32'd0);
        check("snap_done_count", done_cnt - d0, 32'd1);

        // back-to-back: START in the DONE cycle
        set_inputs(8'h00, 16'h1234, 16'h0000, 16'h0000, 16'h0000);
        exp_bytes = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h26};
        pulse_start();
        recv_frame(r0);
        set_inputs(8'h81, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE);
        wait_done(r0, 1'b1, rd);
        exp_bytes = '{8'hA5, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'h80};
        recv_frame(r1);
        check("b2b_first_tick", r1 - rd, 32'd1);
        wait_done(r1, 1'b0, rd);

        // reset in the middle of byte 5
        set_inputs(8'h3C, 16'hABCD, 16'h0102, 16'h8000, 16'h7FFF);
        d0 = done_cnt;
        pulse_start();
        wait_tx_fall(r0);
        repeat (45) @(posedge CLK_1MHz);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("midrst_tx",   {31'd0, TX},   32'd1);
        check("midrst_busy", {31'd0, BUSY}, 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (15) @(posedge CLK_1MHz);
        @(negedge CLK);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        check("midrst_idle_tx", {31'd0, TX}, 32'd1);

        set_inputs(8'h00, 16'h1234, 16'h0000, 16'h0000, 16'h0000);
        exp_bytes = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h26};
        pulse_start();
        recv_frame(r0);
        wait_done(r0, 1'b0, rd);
        check("midrst_done_count", done_cnt - d0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/out_frame_tx.md
OUT_FRAME_TX -- requirements
Module: out_frame_tx

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b1, TX line level when idle and for the stop bit.
REQ-003 SHALL have port CLK  input  1  system clock; all logic in this domain.
REQ-004 SHALL have port RST  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-005 SHALL have port CLK_1MHz  input  1  1 MHz reference, sampled as data; each rising edge is one bit time.
REQ-006 SHALL have port START  input  1  single-cycle request to snapshot and send one frame.
REQ-007 SHALL have port FLAGS  input  8  bit flags {OUT15..OUT8}, MSB = OUT15.
REQ-008 SHALL have ports WORD1, WORD2, WORD3  input  16 each  unsigned words.
REQ-009 SHALL have port WORD4  input  16  signed word, sent as raw two's-complement bits.
REQ-010 SHALL have port TX  output  1  serial line, 8N1, LSB first, 1 Mbit/s.
REQ-011 SHALL have port BUSY  output  1  high from START acceptance until frame end.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse at frame end.

Function
REQ-013 SHALL synchronise CLK_1MHz through two flops and derive TICK as a one-CLK pulse on each synchronised rising edge.
REQ-014 SHALL accept START only when BUSY=0; START while BUSY=1 is ignored without effect.
REQ-015 SHALL, on accepted START, latch FLAGS and WORD1..WORD4 in the same edge and assert BUSY on the next cycle; later input changes do not alter the frame.
REQ-016 SHALL send 11 bytes in order: SYNC_BYTE, FLAGS, WORD1[15:8], WORD1[7:0], WORD2 hi/lo, WORD3 hi/lo, WORD4 hi/lo, CHK.
REQ-017 SHALL compute CHK as the XOR of bytes 2..10 (sync byte excluded).
REQ-018 SHALL send each byte as a start bit (0), 8 data bits LSB first, and one stop bit (IDLE_LEVEL), with no gap between bytes; 110 bit times per frame.
REQ-019 SHALL use FSM states IDLE -> START_BIT -> DATA(bit 0..7) -> STOP_BIT -> START_BIT (next byte) or DONE_ST (after byte 11) -> IDLE; every transition except DONE_ST->IDLE occurs only on TICK.
REQ-020 SHALL drive TX low on the first TICK after BUSY rises, and change TX only on TICK.
REQ-021 SHALL end the frame on the TICK that completes the 11th stop bit: that cycle enters DONE_ST; the next cycle pulses DONE for exactly one cycle with BUSY=0.
REQ-022 SHALL accept a START that coincides with the DONE cycle and begin a new frame.
REQ-023 SHALL keep a 4-bit byte index (0..10) and a 3-bit bit index; both clear on leaving DONE_ST.

Reset
REQ-024 SHALL on RST force TX=IDLE_LEVEL, BUSY=0, DONE=0, FSM=IDLE, indices, latched data and synchroniser flops to 0, asynchronously.
REQ-025 SHALL on RST mid-frame abandon the frame without asserting DONE; the first START after RST release starts a fresh frame.

Structure
REQ-026 SHALL place the FSM state enum, FRAME_BYTES=11 and the SYNC_BYTE default in shared package out_frame_pkg.
REQ-027 SHALL implement REQ-013 in sub-module tick_edge_sync (inputs CLK, RST, CLK_1MHz; output TICK).

Verification
REQ-028 SHALL check reset: RST=1 with TX held high -> TX=1, BUSY=0, DONE=0; no TX edges for 20 ticks after release without START.
REQ-029 SHALL check frame content: FLAGS=8'h00, WORD1=16'h1234, WORD2..4=0, START -> bytes A5,00,12,34,00,00,00,00,00,00,26; DONE after 110 ticks.
REQ-030 SHALL check signed data: WORD4=-2 (16'hFFFE), others 0, FLAGS=8'h81 -> bytes 9/10 = FF,FE; CHK=8'h81^8'hFF^8'hFE=8'h80.
REQ-031 SHALL check snapshot and busy rule: change WORD1 and pulse START mid-frame -> frame unchanged, a single DONE, no second frame.
REQ-032 SHALL check back-to-back operation: START in the DONE cycle -> next start bit on the first following TICK, BUSY high again the next cycle.
REQ-033 SHALL check reset mid-frame: RST during byte 5 -> TX=1 immediately, no DONE; a subsequent START sends a full correct 11-byte frame.
